// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side escape decoder.
package uart_pkg;

    localparam logic [7:0] ESC_CHAR_DEFAULT = 8'hB1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ESC  = 1'b1
    } esc_state_t;

endpackage

// File: rtl/uart_out_slot.sv
// Single-entry 8-bit output register with a valid/ready handshake toward downstream.
module uart_out_slot (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       free_o
);

    // Handshake: a byte transfers on a cycle where valid_o && ready_i. Once raised,
    // valid_o and data_o hold until that transfer. The slot may be reloaded in the
    // transfer cycle, giving one byte per cycle when ready_i stays high.
    assign free_o = !valid_o || ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o  <= 8'h00;
            valid_o <= 1'b0;
        end else if (load_i) begin
            data_o  <= data_i;
            valid_o <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_esc_decoder.sv
// Splits the UART RX byte stream into payload data and escape-introduced command bytes,
// restoring escaped literals and aborting escape sequences that sit idle too long.
module uart_esc_decoder
    import uart_pkg::*;
#(
    parameter logic [7:0]  ESC_CHAR    = ESC_CHAR_DEFAULT,
    parameter int unsigned ESC_TIMEOUT = 1024
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       RX_EMPTY_I,
    input  logic [7:0] DREC_I,
    output logic       RE_O,
    output logic       ESC_DETECTED_O,
    output logic [7:0] DATA_O,
    output logic       DATA_VALID_O,
    input  logic       DATA_READY_I,
    output logic [7:0] CMD_O,
    output logic       CMD_VALID_O,
    input  logic       CMD_READY_I,
    output logic       TIMEOUT_O,
    output esc_state_t DBG_STATE_O
);

    localparam int unsigned      CNT_W    = $clog2(ESC_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ESC_TIMEOUT - 1);

    esc_state_t       state;
    logic [CNT_W-1:0] esc_cnt;
    logic             head_is_esc;
    logic             data_free;
    logic             cmd_free;
    logic             data_load;
    logic             cmd_load;
    logic             re;

    assign head_is_esc = (DREC_I == ESC_CHAR);

    // A byte is popped only once its destination is known to have room; a lone
    // escape in IDLE needs no slot because it only changes state.
    always_comb begin
        re        = 1'b0;
        data_load = 1'b0;
        cmd_load  = 1'b0;
        if (!RST_I && !RX_EMPTY_I) begin
            case (state)
                ST_IDLE: begin
                    if (head_is_esc) begin
                        re = 1'b1;
                    end else if (data_free) begin
                        re        = 1'b1;
                        data_load = 1'b1;
                    end
                end
                ST_ESC: begin
                    if (head_is_esc) begin
                        if (data_free) begin
                            re        = 1'b1;
                            data_load = 1'b1;
                        end
                    end else if (cmd_free) begin
                        re       = 1'b1;
                        cmd_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state   <= ST_IDLE;
            esc_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (re && head_is_esc) begin
                        state   <= ST_ESC;
                        esc_cnt <= '0;
                    end
                end
                ST_ESC: begin
                    // Only an empty FIFO ages the sequence; a stalled byte is backpressure.
                    if (re) begin
                        state <= ST_IDLE;
                    end else if (RX_EMPTY_I) begin
                        if (esc_cnt == CNT_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            esc_cnt <= esc_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Expiry is judged in the same cycle as byte arrival so an arriving byte wins.
    assign TIMEOUT_O      = !RST_I && (state == ST_ESC) && RX_EMPTY_I && (esc_cnt == CNT_LAST);
    assign ESC_DETECTED_O = !RST_I && (state == ST_ESC);
    assign RE_O           = re;
    assign DBG_STATE_O    = state;

    uart_out_slot u_data_slot (
        .clk_i   (CLK_I),
        .rst_i   (RST_I),
        .load_i  (data_load),
        .data_i  (DREC_I),
        .ready_i (DATA_READY_I),
        .data_o  (DATA_O),
        .valid_o (DATA_VALID_O),
        .free_o  (data_free)
    );

    uart_out_slot u_cmd_slot (
        .clk_i   (CLK_I),
        .rst_i   (RST_I),
        .load_i  (cmd_load),
        .data_i  (DREC_I),
        .ready_i (CMD_READY_I),
        .data_o  (CMD_O),
        .valid_o (CMD_VALID_O),
        .free_o  (cmd_free)
    );

endmodule

// File: tb/tb_uart_esc_decoder.sv
// Scoreboard bench for uart_esc_decoder: a FIFO model feeds bytes, a monitor checks both output channels.
module tb_uart_esc_decoder;
    import uart_pkg::*;

    localparam int TO = 16;

    logic       CLK_I;
    logic       RST_I;
    logic       RX_EMPTY_I;
    logic [7:0] DREC_I;
    logic       RE_O;
    logic       ESC_DETECTED_O;
    logic [7:0] DATA_O;
    logic       DATA_VALID_O;
    logic       DATA_READY_I;
    logic [7:0] CMD_O;
    logic       CMD_VALID_O;
    logic       CMD_READY_I;
    logic       TIMEOUT_O;
    esc_state_t DBG_STATE_O;

    uart_esc_decoder #(.ESC_CHAR(8'hB1), .ESC_TIMEOUT(TO)) dut (
        .CLK_I          (CLK_I),
        .RST_I          (RST_I),
        .RX_EMPTY_I     (RX_EMPTY_I),
        .DREC_I         (DREC_I),
        .RE_O           (RE_O),
        .ESC_DETECTED_O (ESC_DETECTED_O),
        .DATA_O         (DATA_O),
        .DATA_VALID_O   (DATA_VALID_O),
        .DATA_READY_I   (DATA_READY_I),
        .CMD_O          (CMD_O),
        .CMD_VALID_O    (CMD_VALID_O),
        .CMD_READY_I    (CMD_READY_I),
        .TIMEOUT_O      (TIMEOUT_O),
        .DBG_STATE_O    (DBG_STATE_O)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    logic [7:0] rx_q[$];
    logic [7:0] data_exp_q[$];
    logic [7:0] cmd_exp_q[$];

    int n_checks;
    int n_pass;
    int re_seen;
    int esc_seen;
    int to_seen;
    int cmd_xfer;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(negedge CLK_I);
    endtask

    task automatic fifo_refresh();
        RX_EMPTY_I = (rx_q.size() == 0);
        DREC_I     = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    endtask

    // FIFO model: pops on the edge where RE_O was high, presents the new head shortly after.
    task automatic fifo_loop();
        logic re_was;
        forever begin
            @(posedge CLK_I);
            re_was = RE_O;
            #1;
            if (re_was && rx_q.size() > 0) void'(rx_q.pop_front());
            fifo_refresh();
            @(negedge CLK_I);
            #1;
            fifo_refresh();
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge CLK_I);
            #2;
            if (!RST_I) begin
                if (RE_O) re_seen++;
                if (ESC_DETECTED_O) esc_seen++;
                if (TIMEOUT_O) to_seen++;
                if (DATA_VALID_O && DATA_READY_I) begin
                    if (data_exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL data_unexpected: got %02h, expected no data output", DATA_O);
                    end else begin
                        check("data_out", 32'(DATA_O), 32'(data_exp_q.pop_front()));
                    end
                end
                if (CMD_VALID_O && CMD_READY_I) begin
                    cmd_xfer++;
                    if (cmd_exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL cmd_unexpected: got %02h, expected no command output", CMD_O);
                    end else begin
                        check("cmd_out", 32'(CMD_O), 32'(cmd_exp_q.pop_front()));
                    end
                end
            end
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            #3;
            done = (rx_q.size() == 0) && (data_exp_q.size() == 0) && (cmd_exp_q.size() == 0);
        end
        check({name, "_drain"}, 32'(done), 32'd1);
    endtask

    int r0, e0, c0, t0;

    initial begin
        n_checks = 0; n_pass = 0;
        re_seen = 0; esc_seen = 0; to_seen = 0; cmd_xfer = 0;
        RST_I = 1'b1; RX_EMPTY_I = 1'b1; DREC_I = 8'h00;
        DATA_READY_I = 1'b1; CMD_READY_I = 1'b1;
        fork
            fifo_loop();
            monitor_loop();
        join_none

        repeat (2) step();
        #2;
        check("rst_data_valid", 32'(DATA_VALID_O), 32'd0);
        check("rst_cmd_valid", 32'(CMD_VALID_O), 32'd0);
        check("rst_data", 32'(DATA_O), 32'h00);
        check("rst_cmd", 32'(CMD_O), 32'h00);
        check("rst_esc_det", 32'(ESC_DETECTED_O), 32'd0);
        check("rst_state", 32'(DBG_STATE_O), 32'(ST_IDLE));
        step();
        RST_I = 1'b0;

        // plain stream, three bytes back to back
        step();
        r0 = re_seen; c0 = cmd_xfer;
        push(8'h01); push(8'h02); push(8'h03);
        data_exp_q.push_back(8'h01); data_exp_q.push_back(8'h02); data_exp_q.push_back(8'h03);
        for (int k = 0; k < 3; k++) begin
            step(); #2;
            check("s1_valid_run", 32'(DATA_VALID_O), 32'd1);
        end
        step(); #2;
        check("s1_valid_end", 32'(DATA_VALID_O), 32'd0);
        #1;
        check("s1_re_cycles", 32'(re_seen - r0), 32'd3);
        check("s1_no_cmd", 32'(cmd_xfer - c0), 32'd0);

        // escaped literal
        step();
        e0 = esc_seen; c0 = cmd_xfer;
        push(8'hB1); push(8'hB1);
        data_exp_q.push_back(8'hB1);
        wait_drain("s2");
        check("s2_esc_cycles", 32'(esc_seen - e0), 32'd1);
        check("s2_no_cmd", 32'(cmd_xfer - c0), 32'd0);

        // command after an idle wait, then data
        step();
        c0 = cmd_xfer;
        push(8'hB1);
        for (int k = 0; k < 3; k++) begin
            step(); #2;
            check("s3_esc_wait", 32'(ESC_DETECTED_O), 32'd1);
        end
        step();
        push(8'h05); push(8'hAA);
        cmd_exp_q.push_back(8'h05);
        data_exp_q.push_back(8'hAA);
        wait_drain("s3");
        check("s3_cmd_count", 32'(cmd_xfer - c0), 32'd1);

        // data backpressure with four bytes queued
        step();
        DATA_READY_I = 1'b0;
        r0 = re_seen;
        push(8'h10); push(8'h20); push(8'h30); push(8'h40);
        data_exp_q.push_back(8'h10); data_exp_q.push_back(8'h20);
        data_exp_q.push_back(8'h30); data_exp_q.push_back(8'h40);
        for (int k = 0; k < 5; k++) begin
            step(); #2;
            check("s4_hold_valid", 32'(DATA_VALID_O), 32'd1);
            check("s4_hold_data", 32'(DATA_O), 32'h10);
        end
        #1;
        check("s4_single_pop", 32'(re_seen - r0), 32'd1);
        check("s4_fifo_left", 32'(rx_q.size()), 32'd3);
        step();
        DATA_READY_I = 1'b1;
        wait_drain("s4");

        // escape timeout with an empty FIFO
        step();
        t0 = to_seen;
        push(8'hB1);
        for (int k = 1; k <= 17; k++) begin
            step(); #2;
            if (k == 15) check("s5_no_early_timeout", 32'(TIMEOUT_O), 32'd0);
            if (k == 16) begin
                check("s5_timeout", 32'(TIMEOUT_O), 32'd1);
                check("s5_esc_at_timeout", 32'(ESC_DETECTED_O), 32'd1);
            end
            if (k == 17) begin
                check("s5_esc_after", 32'(ESC_DETECTED_O), 32'd0);
                check("s5_state_after", 32'(DBG_STATE_O), 32'(ST_IDLE));
            end
        end
        #1;
        check("s5_pulse_count", 32'(to_seen - t0), 32'd1);
        step();
        push(8'h42);
        data_exp_q.push_back(8'h42);
        wait_drain("s5");

        // byte arriving in the expiry cycle wins over the timeout
        step();
        t0 = to_seen;
        push(8'hB1);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 16) begin
                push(8'h07);
                cmd_exp_q.push_back(8'h07);
            end
            #2;
            if (k == 16) begin
                check("s5b_no_timeout", 32'(TIMEOUT_O), 32'd0);
                check("s5b_pop", 32'(RE_O), 32'd1);
            end
        end
        wait_drain("s5b");
        check("s5b_pulse_count", 32'(to_seen - t0), 32'd0);

        // reset while escaped with a command held
        step();
        CMD_READY_I = 1'b0;
        push(8'hB1); push(8'h05); push(8'hB1); push(8'h07);
        repeat (6) step();
        #2;
        check("s6_pre_esc", 32'(ESC_DETECTED_O), 32'd1);
        check("s6_pre_cmd_valid", 32'(CMD_VALID_O), 32'd1);
        check("s6_pre_cmd", 32'(CMD_O), 32'h05);
        check("s6_pre_fifo", 32'(rx_q.size()), 32'd1);
        step();
        RST_I = 1'b1;
        data_exp_q.delete();
        cmd_exp_q.delete();
        #2;
        check("s6_rst_re", 32'(RE_O), 32'd0);
        check("s6_rst_esc", 32'(ESC_DETECTED_O), 32'd0);
        step(); #2;
        check("s6_data_valid", 32'(DATA_VALID_O), 32'd0);
        check("s6_cmd_valid", 32'(CMD_VALID_O), 32'd0);
        check("s6_cmd", 32'(CMD_O), 32'h00);
        check("s6_data", 32'(DATA_O), 32'h00);
        check("s6_state", 32'(DBG_STATE_O), 32'(ST_IDLE));
        step();
        RST_I = 1'b0;
        CMD_READY_I = 1'b1;
        data_exp_q.push_back(8'h07);
        wait_drain("s6");

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
